// File: rtl/spi_slv16.sv
// Mode-3 SPI responder: captures a WIDTH-bit command on MOSI while returning tx_data on MISO.
// Define SPI_SLV_FRM_ERR_EN to add the frm_err pulse and the saturating err_cnt outputs.
module spi_slv16 #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             rdy,
    output logic             busy
`ifdef SPI_SLV_FRM_ERR_EN
    ,
    output logic             frm_err,
    output logic [7:0]       err_cnt
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    state_t state, state_nxt;

    // Bit SS-1 is the synced level, bit SS is the history flop used for edges.
    logic [SS:0] ss_pipe, sclk_pipe, mosi_pipe;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

    logic [WIDTH-1:0] tx_sh, rx_sh;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_pipe   <= '1;
            sclk_pipe <= '1;
            mosi_pipe <= '0;
        end else begin
            ss_pipe   <= {ss_pipe[SS-1:0], SS_n};
            sclk_pipe <= {sclk_pipe[SS-1:0], SCLK};
            mosi_pipe <= {mosi_pipe[SS-1:0], MOSI};
        end
    end

    assign ss_fall   =  ss_pipe[SS]   & ~ss_pipe[SS-1];
    assign ss_rise   = ~ss_pipe[SS]   &  ss_pipe[SS-1];
    assign sclk_rise = ~sclk_pipe[SS] &  sclk_pipe[SS-1];
    assign sclk_fall =  sclk_pipe[SS] & ~sclk_pipe[SS-1];
    assign mosi_s    =  mosi_pipe[SS-1];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = ACTIVE;
            ACTIVE:  if (ss_rise) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_sh   <= '0;
            rx_sh   <= '0;
            cnt     <= '0;
            rx_data <= '0;
            rdy     <= 1'b0;
            busy    <= 1'b0;
            MISO    <= 1'b0;
`ifdef SPI_SLV_FRM_ERR_EN
            frm_err <= 1'b0;
            err_cnt <= '0;
`endif
        end else begin
            rdy <= 1'b0;
`ifdef SPI_SLV_FRM_ERR_EN
            frm_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        tx_sh <= tx_data;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (sclk_rise) begin
                        rx_sh <= {rx_sh[WIDTH-2:0], mosi_s};
                        if (cnt != '1) cnt <= cnt + 1'b1;
                    end
                    // The leading fall after SS_n drops must not shift out the MSB.
                    if (sclk_fall && cnt != '0)
                        tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
                end
                DONE: begin
                    busy <= 1'b0;
                    if (cnt == FULL) begin
                        rx_data <= rx_sh;
                        rdy     <= 1'b1;
                    end
`ifdef SPI_SLV_FRM_ERR_EN
                    else begin
                        frm_err <= 1'b1;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end
`endif
                end
                default: ;
            endcase
            MISO <= (state == ACTIVE) ? tx_sh[WIDTH-1] : 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_slv16.sv
// Bench for spi_slv16: bench-side mode-3 master at clk/32 plus an rdy scoreboard on rx_data.
module tb_spi_slv16;
    localparam int H = 16;

    logic clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, SCLK = 1'b1, MOSI = 1'b0;
    logic MISO, rdy, busy;
    logic [15:0] tx_data = '0, rx_data;
`ifdef SPI_SLV_FRM_ERR_EN
    logic frm_err;
    logic [7:0] err_cnt;
    int frm_cnt = 0;
`endif

    int total = 0, bad = 0, rdy_cnt = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    spi_slv16 #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .tx_data(tx_data), .rx_data(rx_data), .rdy(rdy), .busy(busy)
`ifdef SPI_SLV_FRM_ERR_EN
        , .frm_err(frm_err), .err_cnt(err_cnt)
`endif
    );

    // Scoreboard: every rdy pulse must match the oldest expected command.
    always @(negedge clk) begin
        if (rdy === 1'b1) begin
            logic [15:0] e;
            rdy_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_rdy rx_data=%h with nothing expected", rx_data);
            end else begin
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    bad++;
                    $display("FAIL sb_rx_data got=%h exp=%h", rx_data, e);
                end
            end
        end
`ifdef SPI_SLV_FRM_ERR_EN
        if (frm_err === 1'b1) frm_cnt++;
`endif
    end

    task automatic spi_frame(input logic [15:0] cmd, input int nrise, input int chg_at,
                             input logic [15:0] chg_val, input bit keep_ss,
                             output logic [15:0] rd, output logic busy_mid);
        rd = '0;
        busy_mid = 1'b0;
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nrise; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            repeat (H) @(negedge clk);
            SCLK = 1'b1;
            rd = {rd[14:0], MISO};
            repeat (H) @(negedge clk);
            if (i == 0) busy_mid = busy;
            if (i + 1 == chg_at) tx_data = chg_val;
        end
        if (!keep_ss) begin
            SS_n = 1'b1;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (rx_data !== 16'h0) begin bad++; $display("FAIL rst_rx_data got=%h exp=0000", rx_data); end
        total++; if (rdy !== 1'b0)      begin bad++; $display("FAIL rst_rdy got=%b exp=0", rdy); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (MISO !== 1'b0)     begin bad++; $display("FAIL rst_miso got=%b exp=0", MISO); end
    endtask

    task automatic test_basic();
        logic [15:0] rd; logic bm; int r0;
        r0 = rdy_cnt;
        tx_data = 16'h0C05;
        exp_q.push_back(16'h2800);
        spi_frame(16'h2800, 16, -1, '0, 1'b0, rd, bm);
        total++; if (rd !== 16'h0C05)     begin bad++; $display("FAIL basic_rd got=%h exp=0C05", rd); end
        total++; if (rx_data !== 16'h2800) begin bad++; $display("FAIL basic_rx got=%h exp=2800", rx_data); end
        total++; if (bm !== 1'b1)         begin bad++; $display("FAIL basic_busy_mid got=%b exp=1", bm); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
        total++; if (rdy_cnt != r0 + 1)   begin bad++; $display("FAIL basic_rdy_cnt got=%0d exp=%0d", rdy_cnt - r0, 1); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd; logic bm; int r0;
        r0 = rdy_cnt;
        tx_data = 16'hA5A5;
        exp_q.push_back(16'hFFFF);
        spi_frame(16'hFFFF, 16, -1, '0, 1'b0, rd, bm);
        total++; if (rd !== 16'hA5A5) begin bad++; $display("FAIL b2b_rd0 got=%h exp=A5A5", rd); end
        tx_data = 16'h5A5A;
        exp_q.push_back(16'h0001);
        spi_frame(16'h0001, 16, -1, '0, 1'b0, rd, bm);
        total++; if (rd !== 16'h5A5A)      begin bad++; $display("FAIL b2b_rd1 got=%h exp=5A5A", rd); end
        total++; if (rx_data !== 16'h0001) begin bad++; $display("FAIL b2b_rx got=%h exp=0001", rx_data); end
        total++; if (rdy_cnt != r0 + 2)    begin bad++; $display("FAIL b2b_rdy_cnt got=%0d exp=2", rdy_cnt - r0); end
    endtask

    task automatic test_tx_change();
        logic [15:0] rd; logic bm;
        tx_data = 16'h1234;
        exp_q.push_back(16'h3C3C);
        spi_frame(16'h3C3C, 16, 5, 16'hFFFF, 1'b0, rd, bm);
        total++; if (rd !== 16'h1234) begin bad++; $display("FAIL txchg_rd got=%h exp=1234", rd); end
    endtask

    task automatic test_short_frame();
        logic [15:0] rd; logic bm; int r0;
        r0 = rdy_cnt;
`ifdef SPI_SLV_FRM_ERR_EN
        int f0;
        f0 = frm_cnt;
`endif
        tx_data = 16'h7777;
        spi_frame(16'hAAAA, 9, -1, '0, 1'b0, rd, bm);
        total++; if (rdy_cnt != r0)        begin bad++; $display("FAIL short_rdy got=%0d exp=0", rdy_cnt - r0); end
        total++; if (rx_data !== 16'h3C3C) begin bad++; $display("FAIL short_rx_hold got=%h exp=3C3C", rx_data); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL short_busy got=%b exp=0", busy); end
`ifdef SPI_SLV_FRM_ERR_EN
        total++; if (frm_cnt != f0 + 1)  begin bad++; $display("FAIL short_frm_err got=%0d exp=1", frm_cnt - f0); end
        total++; if (err_cnt !== 8'd1)   begin bad++; $display("FAIL short_err_cnt got=%0d exp=1", err_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd; logic bm; int r0;
        r0 = rdy_cnt;
        tx_data = 16'hFFFF;
        spi_frame(16'h5555, 6, -1, '0, 1'b1, rd, bm);
        rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (rx_data !== 16'h0) begin bad++; $display("FAIL rstmid_rx got=%h exp=0000", rx_data); end
        total++; if (rdy_cnt != r0)     begin bad++; $display("FAIL rstmid_rdy got=%0d exp=0", rdy_cnt - r0); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
`ifdef SPI_SLV_FRM_ERR_EN
        total++; if (err_cnt !== 8'd0)  begin bad++; $display("FAIL rstmid_err_cnt got=%0d exp=0", err_cnt); end
`endif
        tx_data = 16'h0BF4;
        exp_q.push_back(16'h2000);
        spi_frame(16'h2000, 16, -1, '0, 1'b0, rd, bm);
        total++; if (rd !== 16'h0BF4)      begin bad++; $display("FAIL rstmid_rd got=%h exp=0BF4", rd); end
        total++; if (rx_data !== 16'h2000) begin bad++; $display("FAIL rstmid_rx2 got=%h exp=2000", rx_data); end
    endtask

    task automatic test_long_frame();
        logic [15:0] rd; logic bm; int r0;
        r0 = rdy_cnt;
        tx_data = 16'h1111;
        spi_frame(16'h4321, 17, -1, '0, 1'b0, rd, bm);
        total++; if (rdy_cnt != r0)        begin bad++; $display("FAIL long_rdy got=%0d exp=0", rdy_cnt - r0); end
        total++; if (rx_data !== 16'h2000) begin bad++; $display("FAIL long_rx_hold got=%h exp=2000", rx_data); end
`ifdef SPI_SLV_FRM_ERR_EN
        total++; if (err_cnt !== 8'd1)     begin bad++; $display("FAIL long_err_cnt got=%0d exp=1", err_cnt); end
`endif
        tx_data = 16'hBEEF;
        exp_q.push_back(16'h1357);
        spi_frame(16'h1357, 16, -1, '0, 1'b0, rd, bm);
        total++; if (rd !== 16'hBEEF)      begin bad++; $display("FAIL long_next_rd got=%h exp=BEEF", rd); end
        total++; if (rx_data !== 16'h1357) begin bad++; $display("FAIL long_next_rx got=%h exp=1357", rx_data); end
        total++; if (rdy_cnt != r0 + 1)    begin bad++; $display("FAIL long_next_rdy got=%0d exp=1", rdy_cnt - r0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_tx_change();
        test_short_frame();
        test_reset_mid();
        test_long_frame();
        repeat (5) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_missing_rdy pending=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
